// File: rtl/bcd_rtc_clock.sv
// 24-hour BCD real-time clock with seconds prescaler, validated time load,
// minute-resolution alarm and selectable 12h/24h display.
module bcd_rtc_clock #(
    parameter int          TICK_DIV = 1,
    parameter int          TICK_W   = 16,
    parameter logic [7:0]  RESET_HH = 8'h12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode_24h,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ack,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm,
    output logic       sec_tick,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm
);

    logic [7:0]        hr;
    logic [7:0]        mn;
    logic [7:0]        sc;
    logic [TICK_W-1:0] pre;

    logic [7:0] nxt_hr;
    logic [7:0] nxt_mn;
    logic [7:0] nxt_sc;
    logic       tick;
    logic       set_legal;
    logic       set_ok;
    logic       set_bad;
    logic       alarm_hit;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both nibbles decimal, then a plain compare orders BCD correctly.
    function automatic logic bcd_le(input logic [7:0] v,
                                    input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    always_comb begin
        nxt_sc = (sc == 8'h59) ? 8'h00 : bcd_inc(sc);
        nxt_mn = mn;
        nxt_hr = hr;
        if (sc == 8'h59) begin
            nxt_mn = (mn == 8'h59) ? 8'h00 : bcd_inc(mn);
            if (mn == 8'h59)
                nxt_hr = (hr == 8'h23) ? 8'h00 : bcd_inc(hr);
        end
    end

    assign tick      = ena && (pre == TICK_W'(TICK_DIV - 1));
    assign set_legal = bcd_le(set_hh, 8'h23) && bcd_le(set_mm, 8'h59)
                    && bcd_le(set_ss, 8'h59);
    assign set_ok    = set_valid && set_legal;
    assign set_bad   = set_valid && !set_legal;
    // The running time is always legal BCD, so illegal alarm values never match.
    assign alarm_hit = alarm_en && (nxt_hr == alarm_hh)
                    && (nxt_mn == alarm_mm) && (nxt_sc == 8'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr       <= RESET_HH;
            mn       <= 8'h00;
            sc       <= 8'h00;
            pre      <= '0;
            set_ack  <= 1'b0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            set_ack  <= set_ok;
            set_err  <= set_bad;
            sec_tick <= tick && !set_ok;
            alarm    <= tick && !set_ok && alarm_hit;
            if (set_ok) begin
                hr  <= set_hh;
                mn  <= set_mm;
                sc  <= set_ss;
                pre <= '0;
            end else if (tick) begin
                hr  <= nxt_hr;
                mn  <= nxt_mn;
                sc  <= nxt_sc;
                pre <= '0;
            end else if (ena) begin
                pre <= pre + 1'b1;
            end
        end
    end

    // 12h view: 00 -> 12, 13..19 and 22..23 subtract 12, 20..21 borrow across tens.
    always_comb begin
        hh = hr;
        if (!mode_24h) begin
            if (hr == 8'h00)
                hh = 8'h12;
            else if (hr >= 8'h22)
                hh = hr - 8'h12;
            else if (hr >= 8'h20)
                hh = hr - 8'h18;
            else if (hr >= 8'h13)
                hh = hr - 8'h12;
        end
    end

    assign mm = mn;
    assign ss = sc;
    assign pm = (hr >= 8'h12);

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Bench for bcd_rtc_clock: two instances (TICK_DIV 1 and 4) against a
// seconds-of-day reference model, directed scenarios plus random traffic.
module tb_bcd_rtc_clock;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b0;
    logic       mode_24h = 1'b0;
    logic       set_valid = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;

    logic       ack1, err1, al1, st1, pm1;
    logic [7:0] hh1, mm1, ss1;
    logic       ack4, err4, al4, st4, pm4;
    logic [7:0] hh4, mm4, ss4;

    int checks = 0;
    int errors = 0;

    int t[2];
    int p[2];
    bit est[2];
    bit eal[2];
    bit eack, eerr;
    int div[2] = '{1, 4};

    always #5 clk = ~clk;

    bcd_rtc_clock #(.TICK_DIV(1), .TICK_W(16), .RESET_HH(8'h12)) u1 (
        .clk(clk), .reset(reset), .ena(ena), .mode_24h(mode_24h),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm),
        .set_ss(set_ss), .set_ack(ack1), .set_err(err1),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm(al1), .sec_tick(st1), .hh(hh1), .mm(mm1), .ss(ss1),
        .pm(pm1)
    );

    bcd_rtc_clock #(.TICK_DIV(4), .TICK_W(16), .RESET_HH(8'h12)) u4 (
        .clk(clk), .reset(reset), .ena(ena), .mode_24h(mode_24h),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm),
        .set_ss(set_ss), .set_ack(ack4), .set_err(err4),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm(al4), .sec_tick(st4), .hh(hh4), .mm(mm4), .ss(ss4),
        .pm(pm4)
    );

    function automatic int bcd2i(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
            return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    function automatic logic [28:0] expv(input int i);
        int h, m, s, dh;
        h  = t[i] / 3600;
        m  = (t[i] / 60) % 60;
        s  = t[i] % 60;
        dh = mode_24h ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {i2bcd(dh), i2bcd(m), i2bcd(s), (h >= 12),
                est[i], eal[i], eack, eerr};
    endfunction

    function automatic logic [28:0] obsv(input int i);
        if (i == 0)
            return {hh1, mm1, ss1, pm1, st1, al1, ack1, err1};
        return {hh4, mm4, ss4, pm4, st4, al4, ack4, err4};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t[i] = 12 * 3600;
            p[i] = 0;
            est[i] = 1'b0;
            eal[i] = 1'b0;
        end
        eack = 1'b0;
        eerr = 1'b0;
    endtask

    // Advance the model by one clock edge using the current inputs, then clock.
    task automatic cyc();
        int sh, sm, sx, ah, am;
        bit ok;
        sh = bcd2i(set_hh);
        sm = bcd2i(set_mm);
        sx = bcd2i(set_ss);
        ah = bcd2i(alarm_hh);
        am = bcd2i(alarm_mm);
        ok = sh >= 0 && sh <= 23 && sm >= 0 && sm <= 59
          && sx >= 0 && sx <= 59;
        eack = set_valid && ok;
        eerr = set_valid && !ok;
        for (int i = 0; i < 2; i++) begin
            est[i] = 1'b0;
            eal[i] = 1'b0;
            if (eack) begin
                t[i] = sh * 3600 + sm * 60 + sx;
                p[i] = 0;
            end else if (ena && p[i] == div[i] - 1) begin
                t[i] = (t[i] + 1) % 86400;
                p[i] = 0;
                est[i] = 1'b1;
                eal[i] = alarm_en && ah >= 0 && ah <= 23
                      && am >= 0 && am <= 59
                      && t[i] == ah * 3600 + am * 60;
            end else if (ena) begin
                p[i] = p[i] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
        set_valid = 1'b1;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        cyc();
        set_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obsv(i) !== expv(i)) begin
                errors++;
                $display("FAIL reset[%0d] got %h want %h", i, obsv(i), expv(i));
            end
        end
        checks++;
        if ({hh1, mm1, ss1, pm1} !== {8'h12, 8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_12h got %h:%h:%h pm=%b want 12:00:00 pm=1",
                     hh1, mm1, ss1, pm1);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count();
        mode_24h = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (st1 !== 1'b1) begin
                errors++;
                $display("FAIL count_tick k=%0d got %b want 1", k, st1);
            end
        end
        ena = 1'b0;
        checks++;
        if ({hh1, mm1, ss1, pm1} !== {8'h12, 8'h00, 8'h03, 1'b1}) begin
            errors++;
            $display("FAIL count_time got %h:%h:%h want 12:00:03", hh1, mm1, ss1);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obsv(i) !== expv(i)) begin
                errors++;
                $display("FAIL count[%0d] got %h want %h", i, obsv(i), expv(i));
            end
        end
    endtask

    task automatic test_wrap();
        mode_24h = 1'b0;
        do_set(8'h11, 8'h59, 8'h59);
        checks++;
        if (ack1 !== 1'b1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ack got ack=%b err=%b want 1/0", ack1, err1);
        end
        ena = 1'b1;
        cyc();
        ena = 1'b0;
        checks++;
        if ({hh1, mm1, ss1, pm1} !== {8'h12, 8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL wrap_noon got %h:%h:%h pm=%b want 12:00:00 pm=1",
                     hh1, mm1, ss1, pm1);
        end
        do_set(8'h23, 8'h59, 8'h59);
        ena = 1'b1;
        cyc();
        ena = 1'b0;
        mode_24h = 1'b1;
        #1;
        checks++;
        if ({hh1, mm1, ss1, pm1} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wrap_mid24 got %h:%h:%h pm=%b want 00:00:00 pm=0",
                     hh1, mm1, ss1, pm1);
        end
        mode_24h = 1'b0;
        #1;
        checks++;
        if ({hh1, pm1} !== {8'h12, 1'b0}) begin
            errors++;
            $display("FAIL wrap_mid12 got hh=%h pm=%b want 12 pm=0", hh1, pm1);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obsv(i) !== expv(i)) begin
                errors++;
                $display("FAIL wrap[%0d] got %h want %h", i, obsv(i), expv(i));
            end
        end
    endtask

    task automatic test_prescale();
        int highs;
        highs = 0;
        ena = 1'b0;
        do_set(8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 16; k++) begin
            ena = (k % 2 == 0);
            if (ena)
                highs++;
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obsv(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL prescale[%0d] k=%0d got %h want %h",
                             i, k, obsv(i), expv(i));
                end
            end
            if (highs == 4 && ena) begin
                checks++;
                if (ss4 !== 8'h01 || st4 !== 1'b1) begin
                    errors++;
                    $display("FAIL prescale_first got ss=%h tick=%b want 01/1",
                             ss4, st4);
                end
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_set_err();
        ena = 1'b0;
        do_set(8'h05, 8'h06, 8'h07);
        do_set(8'h24, 8'h00, 8'h00);
        checks++;
        if (err1 !== 1'b1 || ack1 !== 1'b0 || ss1 !== 8'h07) begin
            errors++;
            $display("FAIL set_err_hh got err=%b ack=%b ss=%h want 1/0/07",
                     err1, ack1, ss1);
        end
        do_set(8'h10, 8'h6A, 8'h00);
        checks++;
        if (err1 !== 1'b1 || {hh1, mm1} !== {8'h05, 8'h06}) begin
            errors++;
            $display("FAIL set_err_mm got err=%b %h:%h want 1 05:06",
                     err1, hh1, mm1);
        end
        ena = 1'b1;
        do_set(8'h10, 8'h00, 8'h00);
        ena = 1'b0;
        checks++;
        if (st1 !== 1'b0 || ack1 !== 1'b1 || ss1 !== 8'h00) begin
            errors++;
            $display("FAIL set_vs_tick got tick=%b ack=%b ss=%h want 0/1/00",
                     st1, ack1, ss1);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obsv(i) !== expv(i)) begin
                errors++;
                $display("FAIL set[%0d] got %h want %h", i, obsv(i), expv(i));
            end
        end
    endtask

    task automatic test_alarm();
        alarm_hh = 8'h07;
        alarm_mm = 8'h30;
        for (int r = 0; r < 2; r++) begin
            alarm_en = (r == 0);
            ena = 1'b0;
            do_set(8'h07, 8'h29, 8'h59);
            ena = 1'b1;
            cyc();
            ena = 1'b0;
            checks++;
            if (al1 !== alarm_en || st1 !== 1'b1) begin
                errors++;
                $display("FAIL alarm_fire r=%0d got al=%b tick=%b want %b/1",
                         r, al1, st1, alarm_en);
            end
            cyc();
            checks++;
            if (al1 !== 1'b0) begin
                errors++;
                $display("FAIL alarm_width r=%0d got %b want 0", r, al1);
            end
        end
        alarm_en = 1'b1;
        do_set(8'h07, 8'h30, 8'h00);
        checks++;
        if (al1 !== 1'b0 || al4 !== 1'b0) begin
            errors++;
            $display("FAIL alarm_on_set got %b%b want 00", al1, al4);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        ena = 1'b0;
        do_set(8'h03, 8'h04, 8'h05);
        ena = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #2;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obsv(i) !== expv(i)) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h want %h", i, obsv(i), expv(i));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (st4 !== (k == 4)) begin
                errors++;
                $display("FAIL reset_first_tick k=%0d got %b want %b",
                         k, st4, (k == 4));
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_random();
        int at;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                alarm_hh = i2bcd($urandom_range(0, 23));
                alarm_mm = i2bcd($urandom_range(0, 59));
                if ($urandom_range(0, 4) == 0)
                    alarm_mm = 8'($urandom);
            end
            ena = $urandom_range(0, 2) != 0;
            mode_24h = $urandom_range(0, 1);
            alarm_en = $urandom_range(0, 3) != 0;
            set_valid = $urandom_range(0, 40) == 0;
            case ($urandom_range(0, 3))
                0: begin
                    set_hh = 8'($urandom);
                    set_mm = 8'($urandom);
                    set_ss = 8'($urandom);
                end
                1: begin
                    at = (bcd2i(alarm_hh) * 3600 + bcd2i(alarm_mm) * 60
                        - int'($urandom_range(1, 12)) + 86400) % 86400;
                    set_hh = i2bcd(at / 3600);
                    set_mm = i2bcd((at / 60) % 60);
                    set_ss = i2bcd(at % 60);
                end
                default: begin
                    set_hh = i2bcd($urandom_range(0, 23));
                    set_mm = i2bcd($urandom_range(0, 59));
                    set_ss = i2bcd($urandom_range(0, 59));
                end
            endcase
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obsv(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random[%0d] k=%0d got %h want %h",
                             i, k, obsv(i), expv(i));
                end
            end
        end
        set_valid = 1'b0;
        ena = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_prescale();
        test_set_err();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
